// File: rtl/mux_n.sv
// rtl/mux_n.sv - N-to-1 single-bit multiplexer with a registered output
// Binary mux tree over select, out-of-range codes read as zero and raise sel_err.
module mux_n #(
  parameter int N = 14,
  parameter int m = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] inp,
  input  logic [m-1:0] select,
  output logic         out,
  output logic         sel_err
);

  localparam int P = 1 << m;

  if (N < 2 || N > 1024) begin : g_bad_n
    $fatal(1, "mux_n: N must be in 2..1024");
  end
  if (P < N) begin : g_bad_m
    $fatal(1, "mux_n: 2**m must be >= N");
  end

  // Heap-ordered tree: node k has children 2k+1 / 2k+2, leaves start at P-1.
  logic [2*P-2:0] tree;
  logic           oor;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_data
      assign tree[P-1+i] = inp[i];
    end else begin : g_pad
      assign tree[P-1+i] = 1'b0;
    end
  end

  for (genvar d = 0; d < m; d++) begin : g_level
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      localparam int K = (1 << d) - 1 + j;
      assign tree[K] = select[m-1-d] ? tree[2*K+2] : tree[2*K+1];
    end
  end

  if (P > N) begin : g_range
    localparam logic [m:0] NLIM = (m+1)'(N);
    assign oor = ({1'b0, select} >= NLIM);
  end else begin : g_full
    assign oor = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out     <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      out     <= tree[0];
      sel_err <= oor;
    end
  end

endmodule

// File: tb/tb_mux_n.sv
// tb/tb_mux_n.sv - self-checking bench for mux_n (N=14/m=4 and N=8/m=3)
// Arithmetic reference model compared every cycle, plus directed literal vectors.
module tb_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] inp;
  logic [3:0]  sel;
  logic        out, err;
  logic [7:0]  inp8;
  logic [2:0]  sel8;
  logic        out8, err8;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mux_n #(.N(14), .m(4)) dut14 (
    .clk(clk), .rst(rst), .inp(inp), .select(sel), .out(out), .sel_err(err)
  );

  mux_n #(.N(8), .m(3)) dut8 (
    .clk(clk), .rst(rst), .inp(inp8), .select(sel8), .out(out8), .sel_err(err8)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // {sel_err, out} straight from the selection rule
  function automatic logic [1:0] model(input logic [1023:0] v, input int n, input int s);
    if (s >= n) return 2'b10;
    return {1'b0, v[s]};
  endfunction

  logic [1:0] e14, e8;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e14 <= 2'b00;
      e8  <= 2'b00;
    end else begin
      e14 <= model(1024'(inp), 14, int'(sel));
      e8  <= model(1024'(inp8), 8, int'(sel8));
    end
  end

  always @(negedge clk) begin
    chk("cmp14_out", out, e14[0]);
    chk("cmp14_err", err, e14[1]);
    chk("cmp8_out", out8, e8[0]);
    chk("cmp8_err", err8, e8[1]);
  end

  task automatic step(input string nm, input logic [13:0] v, input logic [3:0] s,
                      input logic eo, input logic ee);
    inp = v;
    sel = s;
    @(posedge clk);
    #1;
    chk({nm, "_out"}, out, eo);
    chk({nm, "_err"}, err, ee);
  endtask

  logic [7:0] pat = 8'b10110010;

  initial begin
    rst  = 1'b0;
    inp  = '0;
    sel  = '0;
    inp8 = '0;
    sel8 = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out", out, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_out8", out8, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    step("zero", 14'b00000000000000, 4'd0, 1'b0, 1'b0);
    step("b0s0", 14'b00000000000001, 4'd0, 1'b1, 1'b0);
    step("b0s1", 14'b00000000000001, 4'd1, 1'b0, 1'b0);
    step("top",  14'b10000000000001, 4'd13, 1'b1, 1'b0);
    step("s9",   14'b00000100000001, 4'd9, 1'b0, 1'b0);
    step("s8",   14'b00000100000001, 4'd8, 1'b1, 1'b0);
    step("s5",   14'b00000001000001, 4'd5, 1'b0, 1'b0);
    step("s6",   14'b00000001000001, 4'd6, 1'b1, 1'b0);
    step("oor14", 14'h3FFF, 4'd14, 1'b0, 1'b1);
    step("oor15", 14'h3FFF, 4'd15, 1'b0, 1'b1);
    step("back3", 14'h3FFF, 4'd3, 1'b1, 1'b0);

    // Asynchronous reset between edges while out=1
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 1'b0);
    chk("async_rst_err", err, 1'b0);
    inp = 14'h0004;
    sel = 4'd2;
    @(posedge clk);
    #1;
    chk("held_rst_out", out, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_out", out, 1'b1);
    chk("release_err", err, 1'b0);

    // One-cycle latency on a toggling selected bit
    sel = 4'd3;
    for (int k = 0; k < 8; k++) begin
      inp = '0;
      inp[3] = pat[k];
      if (k > 0) begin
        #2;
        chk("lat_hold", out, pat[k-1]);
      end
      @(posedge clk);
      #1;
      chk("lat_out", out, pat[k]);
    end

    // A pulse that lives entirely between edges must not be captured
    inp = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1 inp = 14'h0008;
    #1 inp = 14'h0000;
    @(posedge clk);
    #1;
    chk("glitch_out", out, 1'b0);

    for (int i = 0; i < 14; i++) begin
      for (int s = 0; s < 16; s++) begin
        inp = '0;
        inp[i] = 1'b1;
        sel = 4'(s);
        @(posedge clk);
        #1;
        chk("sweep14_out", out, (s == i));
        chk("sweep14_err", err, (s >= 14));
      end
    end

    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 8; s++) begin
        inp8 = '0;
        inp8[i] = 1'b1;
        sel8 = 3'(s);
        @(posedge clk);
        #1;
        chk("sweep8_out", out8, (s == i));
        chk("sweep8_err", err8, 1'b0);
      end
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_n.md
Name: mux_n

Overview:
Parameterised N-to-1 single-bit multiplexer with a registered output. It selects one bit of an N-bit input vector using an m-bit index and presents it one clock later. It is a general-purpose selection primitive used wherever a runtime-indexed bit pick from a bus is needed.

Parameters:
N, 14, number of data inputs (width of inp); legal range 2..1024
m, 4, width of select; must satisfy 2^m >= N (elaboration-time check, fatal error if violated)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
inp  input  N  data vector; bit i is data input i
select  input  m  index of the bit to forward, unsigned
out  output  1  registered selected bit
sel_err  output  1  registered flag: select was out of range (select >= N) on the sampled edge

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: while rst=1, out=0 and sel_err=0 immediately, independent of clk. Release is synchronous to the next rising clk edge; the first capture occurs on the first rising edge with rst=0.
- Datapath: on each rising clk edge with rst=0, out <= inp[select] when select < N. Latency is exactly 1 cycle from the sampled inp/select to out. There is no enable: the register captures every cycle.
- Out-of-range select: when N < 2^m and select >= N, out <= 0 and sel_err <= 1. For any in-range select, sel_err <= 0.
- select is treated as an unsigned index. Bit 0 of inp corresponds to select=0, and bit N-1 corresponds to select=N-1.
- No combinational path from inp or select to any output. Outputs change only on a rising clk edge or on assertion of rst.
- Simultaneous events: rst assertion overrides any capture in the same cycle. Changing inp and select together is legal; both are sampled at the same edge.
- X-propagation: out follows the sampled bit. No masking is required beyond the out-of-range rule.
- Implementation: pure sum-of-products or a binary mux tree is acceptable. The result must be identical for all N/m combinations meeting the constraint.

Test Plan:
- Reset: assert rst mid-run with out=1 -> out=0 and sel_err=0 immediately, before the next edge. Release rst -> the first edge captures the current inputs.
- Defaults (N=14, m=4): inp=14'b00000000000000, sel=0 -> out=0 after 1 edge. inp=14'b00000000000001, sel=0 -> out=1. Same inp with sel=1 -> out=0.
- Top index and mid-range selects:
  - inp=14'b10000000000001, sel=13 -> out=1.
  - inp=14'b00000100000001, sel=9 -> out=0; same inp with sel=8 -> out=1.
  - inp=14'b00000001000001, sel=5 -> out=0; sel=6 -> out=1.
- Out of range: inp=14'h3FFF, sel=14 then 15 -> out=0 and sel_err=1 on each. Next sel=3 -> out=1 and sel_err=0.
- Latency: toggle the selected inp bit every cycle -> out reproduces the pattern delayed by exactly one cycle. Changes between edges do not reach out.
- Walking-one sweep: for each i in 0..N-1, inp=1<<i with select swept over 0..2^m-1 -> out=1 only when select=i; sel_err=1 exactly when select>=N. Repeat with N=8, m=3 (no out-of-range codes exist, so sel_err stays 0).
